// File: rtl/crypto_result_serializer.sv
// crypto_result_serializer
//   Captures completed crypto blocks (one-cycle in_valid pulse, no backpressure) into a
//   DEPTH-entry FIFO and serializes each block into OUT_WIDTH-bit beats on a valid/ready
//   stream. The least-significant slice goes first. Packets are framed with m_last.
//
// Optional feature: define CRYPTO_RES_STATS_EN to add the blk_count and drop_count outputs.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      block-done pulse from the engine
//   in_data       completed block (DATA_WIDTH bits)
//   in_space      1 while at least one FIFO slot is free
//   pkt_len       blocks per packet, sampled at the first pop of a packet (0 means 1)
//   m_valid       output beat valid
//   m_data        output beat
//   m_last        last beat of the last block of a packet
//   m_ready       downstream accept
//   fifo_level    blocks held in the FIFO, excluding the block being serialized
//   overflow      sticky flag: a block was dropped
//   clr_overflow  synchronous clear of overflow (a new drop in the same cycle wins)
//   blk_count     (stats only) accepted writes, wraps at 2^32
//   drop_count    (stats only) dropped blocks, saturates at 16'hFFFF
module crypto_result_serializer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned LEVEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_space,
    input  logic [15:0]           pkt_len,
    output logic                  m_valid,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [LEVEL_W-1:0]    fifo_level,
    output logic                  overflow,
    input  logic                  clr_overflow
`ifdef CRYPTO_RES_STATS_EN
    ,
    output logic [31:0]           blk_count,
    output logic [15:0]           drop_count
`endif
);

    localparam int unsigned BEATS  = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    // Elaboration-time parameter checks
    if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_width_chk
        $error("DATA_WIDTH must be an integer multiple of OUT_WIDTH");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 2");
    end

    typedef enum logic {StIdle, StSend} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LEVEL_W-1:0]    level;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [15:0]           blk_cnt;
    logic [15:0]           plen;

    logic                  fifo_empty;
    logic                  handshake;
    logic                  last_beat;
    logic                  blk_done;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;
    logic [15:0]           blk_nxt;
    logic [15:0]           plen_in;

    always_comb begin
        fifo_empty = (level == '0);
        handshake  = m_valid && m_ready;
        last_beat  = (beat_cnt == BEAT_W'(BEATS - 1));
        blk_done   = handshake && last_beat;
        // Pop when idle, or chain the next block on the final beat so there is no bubble
        pop        = !fifo_empty && ((state == StIdle) || blk_done);
        // A full FIFO still accepts a write when a slot frees up in the same cycle
        wr_en      = in_valid && ((level < LEVEL_W'(DEPTH)) || pop);
        drop       = in_valid && !wr_en;
        plen_in    = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
        blk_nxt    = blk_cnt;
        if (blk_done) begin
            blk_nxt = (blk_cnt == plen - 16'd1) ? 16'd0 : blk_cnt + 16'd1;
        end
    end

    assign in_space   = (level < LEVEL_W'(DEPTH));
    assign fifo_level = level;
    assign m_data     = shift[OUT_WIDTH-1:0];
    assign m_last     = m_valid && last_beat && (blk_cnt == plen - 16'd1);

    // FIFO storage needs no reset; the level counter guards every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (pop && !wr_en) begin
                level <= level - LEVEL_W'(1);
            end
        end
    end

    // Serializer FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            m_valid  <= 1'b0;
            shift    <= '0;
            beat_cnt <= '0;
            blk_cnt  <= '0;
            plen     <= '0;
        end else begin
            blk_cnt <= blk_nxt;
            if (pop) begin
                shift    <= mem[rd_ptr];
                beat_cnt <= '0;
                state    <= StSend;
                m_valid  <= 1'b1;
                // Packet length is fixed for the whole packet at its first block
                if (blk_nxt == 16'd0) begin
                    plen <= plen_in;
                end
            end else if (handshake) begin
                shift <= shift >> OUT_WIDTH;
                if (last_beat) begin
                    state   <= StIdle;
                    m_valid <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef CRYPTO_RES_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count  <= '0;
            drop_count <= '0;
        end else begin
            if (wr_en) begin
                blk_count <= blk_count + 32'd1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crypto_result_serializer.sv
// Testbench for crypto_result_serializer: directed scenarios plus a randomized phase.
// A queue-based reference model runs on the clock edge and queues expected beats; a monitor
// on the falling edge compares every presented beat and the status outputs.
module tb_crypto_result_serializer;

    localparam int DW    = 128;
    localparam int OW    = 32;
    localparam int DEPTH = 4;
    localparam int BEATS = DW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_space;
    logic [15:0]   pkt_len = 16'd1;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          clr_overflow = 1'b0;
`ifdef CRYPTO_RES_STATS_EN
    logic [31:0]   blk_count;
    logic [15:0]   drop_count;
`endif

    crypto_result_serializer #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_space     (in_space),
        .pkt_len      (pkt_len),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef CRYPTO_RES_STATS_EN
        ,
        .blk_count    (blk_count),
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    logic [DW-1:0] mq[$];     // blocks waiting in the FIFO
    beat_t         exp_q[$];  // beats expected on the stream, in order
    bit            busy;      // a block is being serialized
    int            left;      // beats of that block not yet accepted
    int            blk;       // position of next/current block within its packet
    int            plen;
    bit            ovf;
    int unsigned   mblk;
    int unsigned   mdrop;
    bit            hs, done, pop, wr;
    logic [DW-1:0] cur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            busy  = 0;
            left  = 0;
            blk   = 0;
            plen  = 1;
            ovf   = 0;
            mblk  = 0;
            mdrop = 0;
        end else begin
            hs   = busy && m_ready;
            done = hs && (left == 1);
            pop  = (mq.size() > 0) && (!busy || done);
            wr   = in_valid && ((mq.size() < DEPTH) || pop);
            if (in_valid && !wr) begin
                ovf = 1;
                if (mdrop < 16'hFFFF) mdrop++;
            end else if (clr_overflow) begin
                ovf = 0;
            end
            if (wr) mblk++;
            if (hs) left--;
            if (done) begin
                blk  = (blk == plen - 1) ? 0 : blk + 1;
                busy = 0;
            end
            if (pop) begin
                cur = mq.pop_front();
                if (blk == 0) plen = (pkt_len == 0) ? 1 : int'(pkt_len);
                for (int b = 0; b < BEATS; b++) begin
                    beat_t e;
                    e.d = cur[b*OW +: OW];
                    e.l = (b == BEATS - 1) && (blk == plen - 1);
                    exp_q.push_back(e);
                end
                busy = 1;
                left = BEATS;
            end
            if (wr) mq.push_back(in_data);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("m_valid", 64'(m_valid), 64'(busy));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(m_data), 64'hDEAD_0000_0000_0000);
                end else begin
                    check("m_data", 64'(m_data), 64'(exp_q[0].d));
                    check("m_last", 64'(m_last), 64'(exp_q[0].l));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("m_last_idle", 64'(m_last), 64'd0);
            end
            check("fifo_level", 64'(fifo_level), 64'(mq.size()));
            check("in_space", 64'(in_space), 64'(mq.size() < DEPTH));
            check("overflow", 64'(overflow), 64'(ovf));
`ifdef CRYPTO_RES_STATS_EN
            check("blk_count", 64'(blk_count), 64'(mblk));
            check("drop_count", 64'(drop_count), 64'(mdrop));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drain(input int n);
        in_valid = 1'b0;
        m_ready  = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [DW-1:0] vec;
    int first_v, last_v, cnt_v;

    initial begin
        do_reset();
        // Reset state
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_in_space", 64'(in_space), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);

        // Single block, known vector, latency of two cycles
        vec      = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        pkt_len  = 16'd1;
        m_ready  = 1'b1;
        in_valid = 1'b1;
        in_data  = vec;
        step();
        in_valid = 1'b0;
        check("lat_n1_m_valid", 64'(m_valid), 64'd0);
        step();
        check("lat_n2_m_valid", 64'(m_valid), 64'd1);
        check("first_beat", 64'(m_data), 64'h03020100);
        drain(6);

        // Three-block packet back-to-back: twelve contiguous beats
        pkt_len = 16'd3;
        first_v = -1;
        last_v  = -1;
        cnt_v   = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 3);
            in_data  = rand_blk();
            step();
            if (m_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                cnt_v++;
            end
        end
        in_valid = 1'b0;
        check("pkt3_beats", 64'(cnt_v), 64'd12);
        check("pkt3_span", 64'(last_v - first_v + 1), 64'd12);

        // Overflow from a fresh reset with the stream stalled
        do_reset();
        pkt_len = 16'd1;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = rand_blk();
            step();
        end
        in_valid = 1'b0;
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'(DEPTH));
        check("ovf_in_space", 64'(in_space), 64'd0);
`ifdef CRYPTO_RES_STATS_EN
        check("ovf_drop_count", 64'(drop_count), 64'd1);
        check("ovf_blk_count", 64'(blk_count), 64'd5);
`endif
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full FIFO with a write coinciding with the last-beat pop
        m_ready = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b1;
        in_data  = rand_blk();
        step();
        in_valid = 1'b0;
        m_ready  = 1'b0;
        check("full_pop_level", 64'(fifo_level), 64'(DEPTH));
        check("full_pop_overflow", 64'(overflow), 64'd0);

        // Alternating ready while the queued blocks stream out
        for (int i = 0; i < 48; i++) begin
            m_ready = i[0];
            step();
        end
        drain(30);

        // Reset asserted mid-packet on beat 2 of block 1
        pkt_len = 16'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = rand_blk();
            step();
        end
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(m_valid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        step();
        rst = 1'b0;
        pkt_len = 16'd2;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = rand_blk();
            step();
        end
        drain(20);

        // Randomized traffic, including drops and pkt_len of 0
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 99) < 30);
            in_data      = rand_blk();
            m_ready      = ($urandom_range(0, 99) < 60);
            clr_overflow = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) pkt_len = 16'($urandom_range(0, 4));
            step();
        end
        clr_overflow = 1'b0;
        drain(60);
        check("end_exp_empty", 64'(exp_q.size()), 64'd0);
        check("end_fifo_empty", 64'(fifo_level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
